ti_adc_frame_aligner: RTL and testbench

TI_ADC_FRAME_ALIGNER -- requirements
Module: ti_adc_frame_aligner

---
 rtl/ti_adc_frame_aligner.sv | 162 ++++++++++++++++
 tb/tb_ti_adc_frame_aligner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_adc_frame_aligner.sv
// ti_adc_frame_aligner
// Collects per-way samples of a time-interleaved ADC into whole frames and
// queues complete frames in a small FIFO for a ready/valid consumer.
// Optional feature macro: TI_ADC_ALIGN_OFFSET_CORR_EN adds a per-way offset
// input; each captured sample becomes clamp(data - offset) with no extra latency.
module ti_adc_frame_aligner #(
  parameter int ADC_WAYS   = 8,
  parameter int ADC_BITS   = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           ADCCLKP,
  input  logic                           CLKRST,
  input  logic [ADC_WAYS*ADC_BITS-1:0]   adc_data,
  input  logic [ADC_WAYS-1:0]            adc_strobe,
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
  input  logic [ADC_WAYS*ADC_BITS-1:0]   offset,
`endif
  output logic [ADC_WAYS*ADC_BITS-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic                           skew_err,
  input  logic                           err_clr
);

  localparam int DW = ADC_WAYS * ADC_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
  // Unsigned sample minus signed offset, saturated to the sample range.
  function automatic logic [ADC_BITS-1:0] sub_clamp(input logic [ADC_BITS-1:0] d,
                                                    input logic [ADC_BITS-1:0] o);
    logic [ADC_BITS+1:0] diff;
    diff = {2'b00, d} - {{2{o[ADC_BITS-1]}}, o};
    if (diff[ADC_BITS+1]) begin
      return {ADC_BITS{1'b0}};
    end else if (diff[ADC_BITS]) begin
      return {ADC_BITS{1'b1}};
    end else begin
      return diff[ADC_BITS-1:0];
    end
  endfunction
`endif

  logic [ADC_WAYS-1:0] got_q, got_d, got_nx_s;
  logic [ADC_BITS-1:0] cap_q [ADC_WAYS];
  logic [ADC_BITS-1:0] cap_d [ADC_WAYS];
  logic [DW-1:0]       frame_s;
  logic                complete_s, skew_set_s;

  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d, rem_s;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_valid_q, ovf_q, skew_q;
  logic                pop_s, full_s, push_ok_s, ovf_set_s, bypass_s;

  // Capture stage: load strobed ways, detect frame completion and re-strobes.
  always_comb begin
    frame_s = {DW{1'b0}};
    for (int k = 0; k < ADC_WAYS; k++) begin
      logic [ADC_BITS-1:0] lane;
      lane = adc_data[k*ADC_BITS +: ADC_BITS];
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
      lane = sub_clamp(lane, offset[k*ADC_BITS +: ADC_BITS]);
`endif
      if (adc_strobe[k]) begin
        cap_d[k] = lane;
      end else begin
        cap_d[k] = cap_q[k];
      end
      frame_s[k*ADC_BITS +: ADC_BITS] = cap_d[k];
    end
    got_nx_s   = got_q | adc_strobe;
    complete_s = &got_nx_s;
    if (complete_s) begin
      got_d = {ADC_WAYS{1'b0}};
    end else begin
      got_d = got_nx_s;
    end
    skew_set_s = (|(adc_strobe & got_q)) & ~complete_s;
  end

  // FIFO control: push/pop arbitration, pointer and level update, next head frame.
  always_comb begin
    pop_s     = out_valid_q & out_ready;
    full_s    = (level_q == LVL_FULL);
    push_ok_s = complete_s & (~full_s | pop_s);
    ovf_set_s = complete_s & full_s & ~pop_s;
    if (push_ok_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
      rem_s  = level_q - LVL_ONE;
    end else begin
      rptr_d = rptr_q;
      rem_s  = level_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // A frame pushed into a FIFO that is (or becomes) empty is the new head.
    bypass_s = push_ok_s & (rem_s == LVL_ZERO);
    if (level_d == LVL_ZERO) begin
      out_data_d = {DW{1'b0}};
    end else if (bypass_s) begin
      out_data_d = frame_s;
    end else begin
      out_data_d = mem_q[rptr_d];
    end
  end

  // State registers with synchronous reset; strobes in the reset cycle are dropped.
  always_ff @(posedge ADCCLKP) begin
    if (CLKRST) begin
      got_q       <= {ADC_WAYS{1'b0}};
      for (int k = 0; k < ADC_WAYS; k++) cap_q[k] <= {ADC_BITS{1'b0}};
      wptr_q      <= {AW{1'b0}};
      rptr_q      <= {AW{1'b0}};
      level_q     <= LVL_ZERO;
      out_data_q  <= {DW{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      skew_q      <= 1'b0;
    end else begin
      got_q       <= got_d;
      for (int k = 0; k < ADC_WAYS; k++) cap_q[k] <= cap_d[k];
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (level_d != LVL_ZERO);
      ovf_q       <= ovf_set_s | (ovf_q & ~err_clr);
      skew_q      <= skew_set_s | (skew_q & ~err_clr);
    end
  end

  // Frame storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge ADCCLKP) begin
    if (!CLKRST && push_ok_s) begin
      mem_q[wptr_q] <= frame_s;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign skew_err   = skew_q;

endmodule

// File: tb/tb_ti_adc_frame_aligner.sv
// Self-checking bench for ti_adc_frame_aligner (8 ways, 9 bits, depth 4).
// A queue-based frame model runs alongside the DUT on every clock.
module tb_ti_adc_frame_aligner;
  localparam int W  = 8;
  localparam int B  = 9;
  localparam int D  = 4;
  localparam int DW = W * B;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic [W-1:0]  adc_strobe;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          skew_err;
  logic          err_clr;
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
  logic [DW-1:0] offset;
`endif

  ti_adc_frame_aligner #(.ADC_WAYS(W), .ADC_BITS(B), .FIFO_DEPTH(D)) dut (
    .ADCCLKP    (clk),
    .CLKRST     (rst),
    .adc_data   (adc_data),
    .adc_strobe (adc_strobe),
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
    .offset     (offset),
`endif
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .skew_err   (skew_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-way flags/values, a queue of frames, sticky flags.
  bit            m_got [W];
  logic [B-1:0]  m_cap [W];
  logic [DW-1:0] m_q [$];
  bit            m_ovf, m_skew;

  typedef struct {
    logic [W-1:0] strobe;
    logic [B-1:0] val;
    logic         exp_valid;
    logic [2:0]   exp_level;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [B-1:0] lane_val(input int k);
    int v;
    v = int'(adc_data[k*B +: B]);
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
    begin
      logic signed [B-1:0] o;
      o = offset[k*B +: B];
      v = v - int'(o);
      if (v < 0) v = 0;
      else if (v > (1 << B) - 1) v = (1 << B) - 1;
    end
`endif
    return v[B-1:0];
  endfunction

  // Apply the frame-building rules to the inputs present before the edge.
  task automatic model_edge();
    bit dup, all, pop, ovf_new;
    logic [DW-1:0] f;
    if (rst) begin
      for (int k = 0; k < W; k++) begin m_got[k] = 1'b0; m_cap[k] = '0; end
      m_q.delete();
      m_ovf = 1'b0; m_skew = 1'b0;
      return;
    end
    dup = 1'b0; ovf_new = 1'b0;
    pop = (m_q.size() != 0) && out_ready;
    for (int k = 0; k < W; k++) begin
      if (adc_strobe[k]) begin
        if (m_got[k]) dup = 1'b1;
        m_cap[k] = lane_val(k);
        m_got[k] = 1'b1;
      end
    end
    all = 1'b1;
    for (int k = 0; k < W; k++) if (!m_got[k]) all = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (all) begin
      for (int k = 0; k < W; k++) begin f[k*B +: B] = m_cap[k]; m_got[k] = 1'b0; end
      if (m_q.size() < D) m_q.push_back(f);
      else ovf_new = 1'b1;
    end
    m_ovf  = ovf_new | (m_ovf & !err_clr);
    m_skew = (dup && !all) | (m_skew & !err_clr);
  endtask

  // One clock: update model, take the edge, compare all outputs 1 ns later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", DW'(out_valid), DW'(m_q.size() != 0));
    chk("level", DW'(fifo_level), DW'(m_q.size()));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("skew_err", DW'(skew_err), DW'(m_skew));
    if (m_q.size() != 0) chk("data", out_data, m_q[0]);
  endtask

  task automatic idle();
    adc_strobe = '0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; adc_strobe = '0; err_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic all_ways(input logic [B-1:0] base);
    for (int k = 0; k < W; k++) adc_data[k*B +: B] = base + B'(k);
    adc_strobe = '1;
    step();
    adc_strobe = '0;
  endtask

  logic [DW-1:0] exp_f;

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k].strobe    = W'(1) << k;
      vecs[k].val       = B'(10 * k);
      vecs[k].exp_valid = (k == 7);
      vecs[k].exp_level = (k == 7) ? 3'd1 : 3'd0;
    end
    adc_data = '0; adc_strobe = '0; out_ready = 1'b0; err_clr = 1'b0; rst = 1'b1;
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
    offset = '0;
`endif
    step();
    step();
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_level", DW'(fifo_level), DW'(0));
    chk("rst_data", out_data, DW'(0));
    idle();

    // Ways one per cycle, way k data = 10k.
    exp_f = '0;
    for (int k = 0; k < 8; k++) begin
      adc_data = '0;
      adc_data[k*B +: B] = vecs[k].val;
      adc_strobe = vecs[k].strobe;
      exp_f[k*B +: B] = B'(10 * k);
      step();
      chk("seq_valid", DW'(out_valid), DW'(vecs[k].exp_valid));
      chk("seq_level", DW'(fifo_level), DW'(vecs[k].exp_level));
    end
    adc_strobe = '0;
    chk("seq_frame", out_data, exp_f);

    // Five full frames with no consumer: fourth fills, fifth drops.
    do_reset();
    adc_data = '1;
    for (int n = 0; n < 5; n++) begin
      adc_strobe = '1;
      step();
      if (n == 3) chk("full_no_ovf", DW'(overflow), DW'(0));
    end
    adc_strobe = '0;
    chk("ovf_level", DW'(fifo_level), DW'(4));
    chk("ovf_flag", DW'(overflow), DW'(1));
    chk("ovf_head", out_data, {DW{1'b1}});

    // Full FIFO, consumer ready, new frame: push and pop both taken.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ovf_clr", DW'(overflow), DW'(0));
    out_ready = 1'b1;
    all_ways(B'(40));
    chk("pp_level", DW'(fifo_level), DW'(4));
    chk("pp_ovf", DW'(overflow), DW'(0));
    for (int n = 0; n < 3; n++) step();
    for (int k = 0; k < W; k++) exp_f[k*B +: B] = B'(40 + k);
    chk("pp_tail", out_data, exp_f);
    step();
    chk("drained", DW'(out_valid), DW'(0));
    out_ready = 1'b0;
    step();
    chk("pop_empty_level", DW'(fifo_level), DW'(0));

    // Way 3 strobed twice before the frame completes.
    do_reset();
    adc_data = '0;
    adc_data[3*B +: B] = B'(5); adc_strobe = 8'h08; step();
    adc_data[3*B +: B] = B'(9); adc_strobe = 8'h08; step();
    chk("skew_set", DW'(skew_err), DW'(1));
    adc_strobe = 8'h77; step();
    adc_strobe = 8'h80; step();
    adc_strobe = '0;
    chk("skew_lane3", DW'(out_data[3*B +: B]), DW'(9));
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("skew_clr", DW'(skew_err), DW'(0));
    // Clear and new error together: error wins.
    adc_strobe = 8'h01; step();
    adc_strobe = 8'h01; err_clr = 1'b1; step();
    idle();
    chk("skew_clr_win", DW'(skew_err), DW'(1));

    // Reset with a partial frame and two frames queued.
    do_reset();
    all_ways(B'(1)); all_ways(B'(2));
    adc_strobe = 8'h1F; step();
    rst = 1'b1; adc_strobe = 8'hE0; step();
    idle();
    chk("rst_mid_valid", DW'(out_valid), DW'(0));
    chk("rst_mid_level", DW'(fifo_level), DW'(0));
    for (int k = 0; k < W; k++) begin adc_strobe = W'(1) << k; step(); end
    adc_strobe = '0; step();
    chk("rst_fresh_level", DW'(fifo_level), DW'(1));

`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
    // Offset correction with clamping at both ends.
    do_reset();
    adc_data = '0; offset = '0;
    adc_data[0*B +: B] = B'(3);   offset[0*B +: B] = B'(5);
    adc_data[1*B +: B] = B'(510); offset[1*B +: B] = -B'(4);
    adc_data[2*B +: B] = B'(100); offset[2*B +: B] = -B'(20);
    adc_strobe = '1; step(); adc_strobe = '0;
    chk("off_lane0", DW'(out_data[0*B +: B]), DW'(0));
    chk("off_lane1", DW'(out_data[1*B +: B]), DW'(511));
    chk("off_lane2", DW'(out_data[2*B +: B]), DW'(120));
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < W; k++) adc_strobe[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) adc_strobe = '1;
      adc_data  = {$urandom, $urandom, $urandom};
`ifdef TI_ADC_ALIGN_OFFSET_CORR_EN
      offset    = {$urandom, $urandom, $urandom};
`endif
      out_ready = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
